// File: rtl/button_strobe_pkg.sv
// Shared definitions for the push-button conditioner: hold-FSM state
// encodings, default timing for the 12 MHz board clock, and a small
// constant helper used to size counters.
package button_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        LONGH = 2'd2
    } state_t;

    localparam int CLK_HZ           = 12_000_000;
    localparam int DEFAULT_DEBOUNCE = 120_000;     // 10 ms settle time
    localparam int DEFAULT_LONG     = 12_000_000;  // 1 s to long-press
    localparam int DEFAULT_REPEAT   = 2_400_000;   // 200 ms auto-repeat period

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous pad input. The reset value is
// a parameter so each pad can come out of reset at its idle level.
module sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Shift the pad value through two flops to settle metastability.
    // NOTE: sequential state uses <= so both flops sample pre-edge values;
    // with = the second flop would see the new s1 and collapse into one stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RESET_VAL;
            q  <= RESET_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_strobe.sv
// Push-button conditioner: synchronise the pad, normalise polarity so that
// 1 means pressed, debounce, then run a press/hold FSM that emits
// single-cycle press, release, long-press and auto-repeat strobes.
module button_strobe
    import button_strobe_pkg::*;
#(
    parameter int DEBOUNCE   = DEFAULT_DEBOUNCE,
    parameter int LONG       = DEFAULT_LONG,
    parameter int REPEAT     = DEFAULT_REPEAT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press_stb,
    output logic release_stb,
    output logic long_stb,
    output logic repeat_stb
);

    localparam int DCNT_W = $clog2(DEBOUNCE + 1);
    // Floor of 1 keeps the hold counter legal when both timers are disabled.
    localparam int HCNT_W = $clog2(max_int(max_int(LONG, REPEAT), 1) + 1);

    localparam logic [DCNT_W-1:0] DCNT_TC   = DCNT_W'(DEBOUNCE - 1);
    localparam logic [HCNT_W-1:0] LONG_TC   = HCNT_W'(LONG - 1);
    localparam logic [HCNT_W-1:0] REPEAT_TC = HCNT_W'(REPEAT - 1);

    logic              s2;
    logic              raw;
    logic [DCNT_W-1:0] dcnt;
    logic              accept;
    logic              press_acc;
    logic              release_acc;

    state_t            state;
    state_t            state_nxt;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_nxt;
    logic              long_nxt;
    logic              repeat_nxt;

    // The synchroniser idles at the released pad level so reset never
    // looks like a press.
    sync2 #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    assign raw = s2 ^ ACTIVE_LOW;

    // A new value is accepted once it has differed from level for DEBOUNCE
    // consecutive evaluations; the direction of the change picks the strobe.
    assign accept      = (raw != level) && (dcnt == DCNT_TC);
    assign press_acc   = accept &  raw;
    assign release_acc = accept & ~raw;

    // Debounce counter, debounced level and the registered edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= 1'b0;
            dcnt        <= '0;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            press_stb   <= press_acc;
            release_stb <= release_acc;
            if (raw == level) begin
                dcnt <= '0;
            end else if (accept) begin
                level <= raw;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + DCNT_W'(1);
            end
        end
    end

    // Hold FSM state, hold counter and registered long/repeat strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            long_stb   <= 1'b0;
            repeat_stb <= 1'b0;
        end else begin
            state      <= state_nxt;
            hcnt       <= hcnt_nxt;
            long_stb   <= long_nxt;
            repeat_stb <= repeat_nxt;
        end
    end

    // Next-state logic: time the hold from the accepted press; an accepted
    // release overrides any terminal count on the same edge.
    // NOTE: every output of this block is assigned a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        hcnt_nxt   = hcnt;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (press_acc) begin
                    state_nxt = HELD;
                    hcnt_nxt  = '0;
                end
            end
            HELD: begin
                if (LONG != 0) begin
                    if (hcnt == LONG_TC) begin
                        long_nxt  = 1'b1;
                        hcnt_nxt  = '0;
                        state_nxt = LONGH;
                    end else begin
                        hcnt_nxt = hcnt + HCNT_W'(1);
                    end
                end
            end
            LONGH: begin
                if (REPEAT != 0) begin
                    if (hcnt == REPEAT_TC) begin
                        repeat_nxt = 1'b1;
                        hcnt_nxt   = '0;
                    end else begin
                        hcnt_nxt = hcnt + HCNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hcnt_nxt  = '0;
            end
        endcase

        if (release_acc) begin
            state_nxt  = IDLE;
            hcnt_nxt   = '0;
            long_nxt   = 1'b0;
            repeat_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_strobe.sv
// Self-checking bench for button_strobe. Two instances share the pad and
// reset: one with LONG=20 and one with LONG=0. A reference model derives
// every expected output from the documented timing rules: a press/release
// is accepted when the last DEBOUNCE raw samples all differ from the
// debounced level, and long/repeat pulses fall at fixed offsets from the
// press edge.
module tb_button_strobe;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;

    logic a_level, a_press, a_release, a_long, a_repeat;
    logic b_level, b_press, b_release, b_long, b_repeat;

    int tests = 0;
    int fails = 0;

    // model state
    bit m_s1, m_s2;
    bit hist[$];
    bit m_level;
    int m_p;
    int cyc = 0;
    bit e_press, e_release;
    bit e_long   [2];
    bit e_repeat [2];

    // observation counters for directed checks (instance a unless noted)
    int cnt_press, cnt_release, cnt_long, cnt_repeat;
    int b_cnt_press, b_cnt_release, b_cnt_long, b_cnt_repeat;
    int press_edge, release_edge, long_edge, first_rep_edge, last_rep_edge;

    int k, m, p, r;

    button_strobe #(.DEBOUNCE(D), .LONG(L), .REPEAT(R), .ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk), .rst (rst), .btn_in (btn_in),
        .level (a_level), .press_stb (a_press), .release_stb (a_release),
        .long_stb (a_long), .repeat_stb (a_repeat)
    );

    button_strobe #(.DEBOUNCE(D), .LONG(0), .REPEAT(R), .ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk), .rst (rst), .btn_in (btn_in),
        .level (b_level), .press_stb (b_press), .release_stb (b_release),
        .long_stb (b_long), .repeat_stb (b_repeat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int long_of(input int c);
        return (c == 0) ? L : 0;
    endfunction

    // Advance the model by one clock edge using the inputs that edge samples.
    task automatic model_edge(input bit b, input bit rv);
        bit raw, acc;
        int d, lg;
        e_press   = 1'b0;
        e_release = 1'b0;
        for (int c = 0; c < 2; c++) begin
            e_long[c]   = 1'b0;
            e_repeat[c] = 1'b0;
        end
        if (rv) begin
            m_s1    = 1'b1;
            m_s2    = 1'b1;
            m_level = 1'b0;
            hist.delete();
        end else begin
            raw = m_s2 ^ 1'b1;
            hist.push_back(raw);
            if (hist.size() > D) void'(hist.pop_front());
            acc = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == m_level) acc = 1'b0;
            if (acc) begin
                m_level = raw;
                if (raw) begin
                    e_press = 1'b1;
                    m_p     = cyc;
                end else begin
                    e_release = 1'b1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                lg = long_of(c);
                if (m_level && !e_press && lg != 0) begin
                    d = cyc - m_p;
                    if (d == lg) e_long[c] = 1'b1;
                    else if (d > lg && ((d - lg) % R) == 0) e_repeat[c] = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
        cyc++;
    endtask

    task automatic clear_counts();
        cnt_press = 0; cnt_release = 0; cnt_long = 0; cnt_repeat = 0;
        b_cnt_press = 0; b_cnt_release = 0; b_cnt_long = 0; b_cnt_repeat = 0;
        press_edge = -1; release_edge = -1; long_edge = -1;
        first_rep_edge = -1; last_rep_edge = -1;
    endtask

    // Drive one cycle of inputs, then compare both instances with the model.
    task automatic step(input logic b, input logic rv);
        int edge_idx;
        btn_in = b;
        rst    = rv;
        @(posedge clk);
        edge_idx = cyc;
        model_edge(b, rv);
        #1;
        check($sformatf("a_level@%0d", edge_idx),   a_level,   m_level);
        check($sformatf("a_press@%0d", edge_idx),   a_press,   e_press);
        check($sformatf("a_release@%0d", edge_idx), a_release, e_release);
        check($sformatf("a_long@%0d", edge_idx),    a_long,    e_long[0]);
        check($sformatf("a_repeat@%0d", edge_idx),  a_repeat,  e_repeat[0]);
        check($sformatf("b_level@%0d", edge_idx),   b_level,   m_level);
        check($sformatf("b_press@%0d", edge_idx),   b_press,   e_press);
        check($sformatf("b_release@%0d", edge_idx), b_release, e_release);
        check($sformatf("b_long@%0d", edge_idx),    b_long,    e_long[1]);
        check($sformatf("b_repeat@%0d", edge_idx),  b_repeat,  e_repeat[1]);
        if (a_press === 1'b1)   begin cnt_press++;   press_edge   = edge_idx; end
        if (a_release === 1'b1) begin cnt_release++; release_edge = edge_idx; end
        if (a_long === 1'b1)    begin cnt_long++;    long_edge    = edge_idx; end
        if (a_repeat === 1'b1) begin
            cnt_repeat++;
            if (first_rep_edge < 0) first_rep_edge = edge_idx;
            last_rep_edge = edge_idx;
        end
        if (b_press === 1'b1)   b_cnt_press++;
        if (b_release === 1'b1) b_cnt_release++;
        if (b_long === 1'b1)    b_cnt_long++;
        if (b_repeat === 1'b1)  b_cnt_repeat++;
        @(negedge clk);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b1;

        // reset and idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check("reset_level", a_level, 1'b0);
        hold(1'b1, 10);

        // bounce: never stable for DEBOUNCE samples
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            hold(1'b0, 3);
            hold(1'b1, 2);
        end
        hold(1'b1, 10);
        check_int("bounce_press_count", cnt_press, 0);
        check_int("bounce_release_count", cnt_release, 0);

        // clean press and release
        clear_counts();
        k = cyc;
        hold(1'b0, 10);
        check("clean_level_pressed", a_level, 1'b1);
        check_int("clean_press_edge", press_edge, k + 5);
        m = cyc;
        hold(1'b1, 10);
        check("clean_level_released", a_level, 1'b0);
        check_int("clean_release_edge", release_edge, m + 5);
        check_int("clean_press_count", cnt_press, 1);
        check_int("clean_release_count", cnt_release, 1);

        // long hold with three auto-repeats
        clear_counts();
        k = cyc;
        p = k + 5;
        hold(1'b0, 50);
        hold(1'b1, 10);
        check_int("long_press_edge", press_edge, p);
        check_int("long_edge", long_edge, p + L);
        check_int("long_count", cnt_long, 1);
        check_int("repeat_count", cnt_repeat, 3);
        check_int("repeat_first_edge", first_rep_edge, p + L + R);
        check_int("repeat_last_edge", last_rep_edge, p + L + 3 * R);
        check_int("long_release_edge", release_edge, p + 50);

        // release accepted on the same edge as the first repeat
        clear_counts();
        k = cyc;
        p = k + 5;
        hold(1'b0, 28);
        hold(1'b1, 20);
        check_int("collide_release_edge", release_edge, p + L + R);
        check_int("collide_repeat_count", cnt_repeat, 0);
        check_int("collide_long_count", cnt_long, 1);

        // reset in the middle of a hold, button kept pressed
        clear_counts();
        k = cyc;
        p = k + 5;
        hold(1'b0, 15);
        step(1'b0, 1'b1);
        check("midrst_level", a_level, 1'b0);
        step(1'b0, 1'b1);
        r = cyc;
        hold(1'b0, 30);
        hold(1'b1, 10);
        check_int("midrst_press_count", cnt_press, 2);
        check_int("midrst_press_edge", press_edge, r + 5);
        check_int("midrst_long_edge", long_edge, r + 5 + L);
        check_int("midrst_release_count", cnt_release, 1);

        // LONG=0 instance over a long hold
        clear_counts();
        hold(1'b0, 100);
        hold(1'b1, 10);
        check_int("nolong_press_count", b_cnt_press, 1);
        check_int("nolong_release_count", b_cnt_release, 1);
        check_int("nolong_long_count", b_cnt_long, 0);
        check_int("nolong_repeat_count", b_cnt_repeat, 0);

        // randomized segments with occasional resets
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(19, 0) == 0) begin
                step(1'($urandom_range(1, 0)), 1'b1);
            end else begin
                hold(1'($urandom_range(1, 0)), int'($urandom_range(40, 1)));
            end
        end
        hold(1'b1, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
